rst_sequencer: RTL

Reset sequencer that drives the reset inputs of downstream blocks, the opposite end of the reset path from the reset synchronizers. Runs in the system clock domain. After its own reset releases, or after a software or watchdog reset request, it holds every output reset asserted for a minimum width. It then releases the outputs one at a time, in index order, with a fixed gap between releases. Outputs are active-low and suitable as the RST inputs of per-domain reset synchronizers.

---
 rtl/rst_seq_pkg.sv | 24 ++
 rtl/rst_seq_wdog.sv | 24 ++
 rtl/rst_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset-cause encodings
// and a counter sizing helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_RST  = 2'b00,
    CAUSE_SW   = 2'b01,
    CAUSE_WDOG = 2'b10
  } cause_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_wdog.sv
// Watchdog for the reset sequencer: counts RUN cycles since the last kick and
// flags expiry one cycle ahead of the edge that re-asserts the outputs.
module rst_seq_wdog #(
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  input  logic kick,
  output logic expire_c
);

  localparam int unsigned W_W = $clog2(WDOG_CYCLES + 1);

  logic [W_W-1:0] wcnt;

  always_ff @(posedge CLK) begin
    if (RST || !run || kick) wcnt <= '0;
    else                     wcnt <= wcnt + W_W'(1);
  end

  assign expire_c = run && !kick && (wcnt == W_W'(WDOG_CYCLES - 1));

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: holds all active-low outputs low for MIN_ASSERT cycles, then
// releases them in index order GAP cycles apart. Watchdog under RST_SEQ_WDOG_EN.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_OUTS    = 3,
  parameter int unsigned MIN_ASSERT  = 16,
  parameter int unsigned GAP         = 8,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SW_RST_REQ,
  output logic                SW_RST_ACK,
  input  logic                WDOG_KICK,
  output logic [NUM_OUTS-1:0] RST_OUT,
  output logic                SEQ_DONE,
  output logic [1:0]          RST_CAUSE
);

  localparam int unsigned CNT_W = $clog2(max3(MIN_ASSERT, GAP, WDOG_CYCLES) + 1);
  localparam int unsigned IDX_W = $clog2(NUM_OUTS + 1);

  if (NUM_OUTS < 1) begin : g_bad_num_outs
    $error("rst_sequencer: NUM_OUTS must be >= 1");
  end
  if (MIN_ASSERT < 2) begin : g_bad_min_assert
    $error("rst_sequencer: MIN_ASSERT must be >= 2");
  end
  if (GAP < 1) begin : g_bad_gap
    $error("rst_sequencer: GAP must be >= 1");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic               start_q;
  logic               expire_c;

`ifdef RST_SEQ_WDOG_EN
  rst_seq_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .CLK      (CLK),
    .RST      (RST),
    .run      (state == RUN),
    .kick     (WDOG_KICK),
    .expire_c (expire_c)
  );
`else
  logic unused_kick;
  assign unused_kick = WDOG_KICK;
  assign expire_c    = 1'b0;
`endif

  // The first edge after RST drops is treated like a request-acceptance edge,
  // so both paths release RST_OUT[i] at MIN_ASSERT + (i+1)*GAP edges later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ASSERT;
      cnt        <= '0;
      idx        <= '0;
      start_q    <= 1'b1;
      RST_OUT    <= '0;
      SEQ_DONE   <= 1'b0;
      SW_RST_ACK <= 1'b0;
      RST_CAUSE  <= CAUSE_RST;
    end else begin
      SW_RST_ACK <= 1'b0;
      start_q    <= 1'b0;
      if (SW_RST_REQ || expire_c) begin
        state      <= ASSERT;
        cnt        <= '0;
        idx        <= '0;
        RST_OUT    <= '0;
        SEQ_DONE   <= 1'b0;
        SW_RST_ACK <= SW_RST_REQ;
        RST_CAUSE  <= SW_RST_REQ ? CAUSE_SW : CAUSE_WDOG;
      end else begin
        case (state)
          ASSERT: begin
            if (start_q) begin
              cnt <= '0;
            end else if (cnt == CNT_W'(MIN_ASSERT - 1)) begin
              state <= RELEASE;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RELEASE: begin
            if (cnt == CNT_W'(GAP - 1)) begin
              RST_OUT[idx] <= 1'b1;
              cnt          <= '0;
              idx          <= idx + IDX_W'(1);
              if (idx == IDX_W'(NUM_OUTS - 1)) begin
                SEQ_DONE <= 1'b1;
                state    <= RUN;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RUN: ;
          default: state <= ASSERT;
        endcase
      end
    end
  end

endmodule
